// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS fetch-stage control logic.
//   PC_WIDTH          : program counter width (32)
//   PC_RESET_DEFAULT  : default fetch address after reset
//   PC_EXC_DEFAULT    : default exception vector
//   pc_seq_state_t    : pc_sequencer FSM state (BOOT, RUN)
//   align_target()    : forces bits [1:0] of a fetch target to zero
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int PC_WIDTH = 32;

    localparam logic [PC_WIDTH-1:0] PC_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [PC_WIDTH-1:0] PC_EXC_DEFAULT   = 32'h0000_0080;

    typedef enum logic {
        PC_SEQ_BOOT = 1'b0,
        PC_SEQ_RUN  = 1'b1
    } pc_seq_state_t;

    // Instruction fetches are word aligned; the low two bits are dropped.
    function automatic logic [PC_WIDTH-1:0] align_target(input logic [PC_WIDTH-1:0] t);
        return t & ~{{(PC_WIDTH-2){1'b0}}, 2'b11};
    endfunction

endpackage

// File: rtl/pc_incrementer.sv
// -----------------------------------------------------------------------------
// pc_incrementer
// Combinational PC + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
//   pc_i        in  32  address
//   pc_plus4_o  out 32  pc_i + 4
// -----------------------------------------------------------------------------
module pc_incrementer
    import mips_pkg::*;
(
    input  logic [PC_WIDTH-1:0] pc_i,
    output logic [PC_WIDTH-1:0] pc_plus4_o
);

    assign pc_plus4_o = pc_i + PC_WIDTH'(4);

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Next-PC controller for the fetch stage. Owns the PC register and chooses
// each cycle between sequential increment, stall hold and redirects.
//
// Optional feature macro: PC_SEQ_EXC_EN
//   defined   : exc_i port present, exception redirect to EXC_PC at top
//               priority, misaligned branch/jump targets redirect to EXC_PC.
//   undefined : no exc_i port, target bits [1:0] are silently masked.
//
// Ports:
//   clk              in   rising-edge clock
//   rst_n            in   synchronous active-low reset
//   stall_i          in   hold the PC
//   branch_taken_i   in   taken branch resolved in EX
//   branch_target_i  in   branch destination
//   jump_i           in   j/jal/jr decoded in ID
//   jump_target_i    in   jump destination
//   exc_i            in   exception request (PC_SEQ_EXC_EN only)
//   pc_o             out  current fetch address
//   pc_plus4_o       out  pc_o + 4, registered with pc_o
//   fetch_valid_o    out  pc_o is a real fetch (0 during boot)
//   flush_ifid_o     out  kill IF/ID (combinational)
//   flush_idex_o     out  kill ID/EX (combinational)
//   redirect_cnt_o   out  saturating count of accepted redirects
//
// Handshake: there is no valid/ready pairing here; every request input is a
// single-cycle level sampled at the rising edge while in RUN. Redirects win
// over stall_i and the flushes they raise are valid in that same cycle.
// -----------------------------------------------------------------------------
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_RESET_DEFAULT,
    parameter logic [PC_WIDTH-1:0] EXC_PC   = PC_EXC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                branch_taken_i,
    input  logic [PC_WIDTH-1:0] branch_target_i,
    input  logic                jump_i,
    input  logic [PC_WIDTH-1:0] jump_target_i,
`ifdef PC_SEQ_EXC_EN
    input  logic                exc_i,
`endif
    output logic [PC_WIDTH-1:0] pc_o,
    output logic [PC_WIDTH-1:0] pc_plus4_o,
    output logic                fetch_valid_o,
    output logic                flush_ifid_o,
    output logic                flush_idex_o,
    output logic [15:0]         redirect_cnt_o
);

    pc_seq_state_t       state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
    logic                fetch_valid_q;
    logic [15:0]         cnt_q, cnt_d;
    logic [PC_WIDTH-1:0] pc_seq;
    logic                redirect;
    logic                flush_ifid;
    logic                flush_idex;

    // Sequential successor of the current PC.
    pc_incrementer u_inc_seq (
        .pc_i       (pc_q),
        .pc_plus4_o (pc_seq)
    );

    // Link/base value, computed from the next PC so it registers alongside it.
    pc_incrementer u_inc_link (
        .pc_i       (pc_d),
        .pc_plus4_o (pc_plus4_d)
    );

`ifdef PC_SEQ_EXC_EN
    function automatic logic [PC_WIDTH-1:0] target_or_exc(input logic [PC_WIDTH-1:0] t);
        // A misaligned fetch target is turned into an exception redirect.
        return (t[1:0] != 2'b00) ? EXC_PC : t;
    endfunction
`else
    function automatic logic [PC_WIDTH-1:0] target_or_exc(input logic [PC_WIDTH-1:0] t);
        return align_target(t);
    endfunction

    logic unused_exc_pc;
    assign unused_exc_pc = ^EXC_PC;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect   = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        case (state_q)
            PC_SEQ_BOOT: begin
                // Requests are ignored; PC stays at RESET_PC for the first fetch.
                state_d = PC_SEQ_RUN;
            end
            PC_SEQ_RUN: begin
                pc_d = pc_seq;
`ifdef PC_SEQ_EXC_EN
                if (exc_i) begin
                    pc_d       = EXC_PC;
                    redirect   = 1'b1;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else
`endif
                // Branch is the older instruction, so it beats a same-cycle jump.
                if (branch_taken_i) begin
                    pc_d       = target_or_exc(branch_target_i);
                    redirect   = 1'b1;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                end else if (jump_i) begin
                    pc_d       = target_or_exc(jump_target_i);
                    redirect   = 1'b1;
                    flush_ifid = 1'b1;
`ifdef PC_SEQ_EXC_EN
                    // A misaligned jump is really an exception: kill ID/EX too.
                    flush_idex = (jump_target_i[1:0] != 2'b00);
`endif
                end else if (stall_i) begin
                    pc_d = pc_q;
                end
            end
            default: begin
                state_d = PC_SEQ_BOOT;
            end
        endcase
    end

    assign cnt_d = (redirect && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= PC_SEQ_BOOT;
            pc_q          <= RESET_PC;
            pc_plus4_q    <= RESET_PC + PC_WIDTH'(4);
            fetch_valid_q <= 1'b0;
            cnt_q         <= 16'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_plus4_d;
            fetch_valid_q <= 1'b1;
            cnt_q         <= cnt_d;
        end
    end

    assign pc_o           = pc_q;
    assign pc_plus4_o     = pc_plus4_q;
    assign fetch_valid_o  = fetch_valid_q;
    assign redirect_cnt_o = cnt_q;
    // Flushes never leak out while reset is held.
    assign flush_ifid_o   = flush_ifid & rst_n;
    assign flush_idex_o   = flush_idex & rst_n;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Directed and random stimulus for pc_sequencer against a behavioural model
// of the fetch-address rules. Build with +define+PC_SEQ_EXC_EN to cover the
// exception feature.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] T_EXC_PC   = 32'h0000_0080;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        exc_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        fetch_valid_o;
    logic        flush_ifid_o;
    logic        flush_idex_o;
    logic [15:0] redirect_cnt_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    bit          m_boot;
    logic [31:0] m_pc;
    bit          m_fv;
    int          m_cnt;

    pc_sequencer #(
        .RESET_PC (T_RESET_PC),
        .EXC_PC   (T_EXC_PC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
`ifdef PC_SEQ_EXC_EN
        .exc_i           (exc_i),
`endif
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4_o),
        .fetch_valid_o   (fetch_valid_o),
        .flush_ifid_o    (flush_ifid_o),
        .flush_idex_o    (flush_idex_o),
        .redirect_cnt_o  (redirect_cnt_o)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Where an accepted target actually sends the fetch.
    function automatic logic [31:0] model_target(input logic [31:0] t);
`ifdef PC_SEQ_EXC_EN
        return (t % 4 != 0) ? T_EXC_PC : t;
`else
        return t - (t % 4);
`endif
    endfunction

    // One clock: drive inputs, check the combinational flushes, take the edge,
    // advance the model, then check the registered outputs.
    task automatic cycle(input logic rst, input logic s, input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt, input logic e, input bit chk);
        bit          exp_fi;
        bit          exp_fe;
        bit          eff_exc;
        bit          redir;
        logic [31:0] tgt;
        rst_n           = rst;
        stall_i         = s;
        branch_taken_i  = b;
        branch_target_i = bt;
        jump_i          = j;
        jump_target_i   = jt;
        exc_i           = e;
`ifdef PC_SEQ_EXC_EN
        eff_exc = e;
`else
        eff_exc = 1'b0;
`endif
        exp_fi = 1'b0;
        exp_fe = 1'b0;
        if (rst && !m_boot) begin
            if (eff_exc || b) begin
                exp_fi = 1'b1;
                exp_fe = 1'b1;
            end else if (j) begin
                exp_fi = 1'b1;
                // A misaligned jump becomes an exception, which kills both stages.
                exp_fe = (model_target(jt) == T_EXC_PC) && (jt % 4 != 0);
            end
        end
        #1;
        if (chk) begin
            check("flush_ifid", flush_ifid_o, exp_fi);
            check("flush_idex", flush_idex_o, exp_fe);
        end
        @(posedge clk);
        if (!rst) begin
            m_boot = 1'b1;
            m_pc   = T_RESET_PC;
            m_fv   = 1'b0;
            m_cnt  = 0;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_fv   = 1'b1;
        end else begin
            redir = 1'b1;
            if (eff_exc)  tgt = T_EXC_PC;
            else if (b)   tgt = model_target(bt);
            else if (j)   tgt = model_target(jt);
            else begin
                redir = 1'b0;
                tgt   = s ? m_pc : m_pc + 32'd4;
            end
            m_pc = tgt;
            if (redir && m_cnt < 65535) m_cnt++;
        end
        #1;
        if (chk) begin
            check("pc", pc_o, m_pc);
            check("pc_plus4", pc_plus4_o, m_pc + 32'd4);
            check("fetch_valid", fetch_valid_o, m_fv);
            check("redirect_cnt", redirect_cnt_o, m_cnt);
        end
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        m_boot = 1'b1;
        m_pc   = T_RESET_PC;
        m_fv   = 1'b0;
        m_cnt  = 0;

        // Reset for three cycles, with a request present that must be ignored.
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1);
        check("reset_pc", pc_o, 32'h0);
        check("reset_fv", fetch_valid_o, 1'b0);

        // BOOT cycle: requests ignored, no flush.
        cycle(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 32'h44, 1'b0, 1'b1);
        check("boot_pc", pc_o, 32'h0);
        check("boot_fv", fetch_valid_o, 1'b1);
        idle();
        idle();
        check("seq_pc8", pc_o, 32'h8);

        // Stall two cycles at 8, then resume.
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle();
        check("after_stall", pc_o, 32'hC);

        // Branch over stall.
        cycle(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1);
        check("br_over_stall", pc_o, 32'h100);
        check("br_cnt", redirect_cnt_o, 32'd1);

        // Branch beats same-cycle jump.
        cycle(1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 32'h200, 1'b0, 1'b1);
        check("br_vs_jump", pc_o, 32'h300);

        // Jump alone with misaligned target.
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h203, 1'b0, 1'b1);
`ifdef PC_SEQ_EXC_EN
        check("jump_misalign", pc_o, 32'h80);
`else
        check("jump_mask", pc_o, 32'h200);
`endif

        // Wrap.
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b1);
        idle();
        check("wrap_pc", pc_o, 32'h0);
        check("wrap_plus4", pc_plus4_o, 32'h4);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'b1,
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 5) == 0), $urandom,
                  ($urandom_range(0, 5) == 0), $urandom,
                  ($urandom_range(0, 15) == 0), 1'b1);
        end

        // Reset during a branch.
        cycle(1'b0, 1'b0, 1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 1'b1);
        check("midreset_pc", pc_o, T_RESET_PC);
        check("midreset_cnt", redirect_cnt_o, 32'd0);
        check("midreset_fv", fetch_valid_o, 1'b0);
        idle();

        // Counter saturation.
        for (int i = 0; i < 65540; i++)
            cycle(1'b1, 1'b0, 1'b1, 32'h1000 + 32'(i % 64) * 4, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'h2000, 1'b0, 32'h0, 1'b0, 1'b1);
        check("sat_cnt", redirect_cnt_o, 32'h0000_FFFF);
        idle();
        check("sat_hold", redirect_cnt_o, 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the pipelined MIPS fetch stage. It owns the program counter register and sequences it on every clock: sequential increment, stall hold, branch/jump redirect and, when compiled in, exception redirect. It also drives the IF/ID and ID/EX flush strobes that accompany each redirect. It sits between the hazard unit, the branch/jump resolution logic and the instruction memory address port.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `EXC_PC`, default 32'h0000_0080: exception vector; used only with `PC_SEQ_EXC_EN`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `stall_i`  in  1  hazard unit holds IF; PC must not advance.
- `branch_taken_i`  in  1  EX stage resolved a taken branch this cycle.
- `branch_target_i`  in  32  branch destination.
- `jump_i`  in  1  ID stage decoded j/jal/jr this cycle.
- `jump_target_i`  in  32  jump destination.
- `exc_i`  in  1  exception request; port exists only with `PC_SEQ_EXC_EN`.
- `pc_o`  out  32  current fetch address (registered).
- `pc_plus4_o`  out  32  `pc_o`+4 (registered), forwarded to IF/ID for link/branch base.
- `fetch_valid_o`  out  1  `pc_o` is a real fetch; 0 during boot.
- `flush_ifid_o`  out  1  kill IF/ID contents (combinational).
- `flush_idex_o`  out  1  kill ID/EX contents (combinational).
- `redirect_cnt_o`  out  16  saturating count of accepted redirects.

## Operation
- States: BOOT, RUN. Reset forces BOOT.
- BOOT: lasts exactly one cycle after `rst_n` goes high. All request inputs are ignored, flushes are 0, and `pc_o` holds `RESET_PC`. The next state is RUN, and `fetch_valid_o` becomes 1.
- RUN: the next PC is chosen by fixed priority:
  - exception (if enabled): next PC = `EXC_PC`; assert `flush_ifid_o` and `flush_idex_o`.
  - `branch_taken_i`: next PC = `branch_target_i`; assert both flushes.
  - `jump_i`: next PC = `jump_target_i`; assert `flush_ifid_o` only.
  - `stall_i`: PC is held; no flush.
  - otherwise: PC + 4.
- Redirects override `stall_i`. The stalled instructions are younger than the redirect and are flushed.
- Branch beats a same-cycle jump, because the branch is the older instruction.
- Targets are used with bits [1:0] forced to 0.
- Arithmetic: PC + 4 is modulo 2^32, so 32'hFFFF_FFFC advances to 32'h0000_0000. `pc_plus4_o` is computed from the next PC and registered together with it.
- `redirect_cnt_o` increments on each cycle a redirect is taken in RUN. It saturates at 16'hFFFF.
- Reset mid-operation: when `rst_n` is low at a rising edge, all state returns to reset values regardless of other inputs, and the sequence restarts at BOOT.
- Reset values:
  - `pc_o` = `RESET_PC`
  - `pc_plus4_o` = `RESET_PC`+4
  - `fetch_valid_o` = 0
  - `redirect_cnt_o` = 0
  - flushes = 0
  - state = BOOT

## Timing
- PC redirect latency is 1 cycle: a request sampled at edge N produces `pc_o` = target after edge N.
- Flush outputs are asserted in the same cycle as the request. They are combinational from the inputs and the state, and are gated to 0 in BOOT and while `rst_n` = 0.
- Stall: when `stall_i` is high in cycle N, `pc_o` and `pc_plus4_o` are unchanged after edge N.
- First real fetch: `RESET_PC` is valid starting on the second cycle after reset release.

## Configuration
- `PC_SEQ_EXC_EN` defined:
  - `exc_i` port and `EXC_PC` redirect are present, at top priority.
  - A non-zero bits [1:0] on an accepted branch/jump target redirects to `EXC_PC` instead (misaligned fetch). This still asserts both flushes and counts once.
- Undefined:
  - No `exc_i` port.
  - Target bits [1:0] are silently masked.
  - `EXC_PC` is unused.

## Structure
- Shared package `mips_pkg`:
  - the `pc_seq_state_t` enum (BOOT, RUN);
  - `PC_WIDTH` = 32;
  - default `RESET_PC` and `EXC_PC` constants.
- One sub-module, `pc_incrementer`: a combinational 32-bit +4 with wrap. It is instanced once for the next-PC increment and once for `pc_plus4_o`.
- The priority mux, state register, PC register and counter live in the top module.

## Test plan
- Reset/boot: hold `rst_n`=0 for 3 cycles, then release with `RESET_PC`=0. Expect `pc_o`=0 and `fetch_valid_o`=0 for 1 cycle, then `fetch_valid_o`=1 and `pc_o` stepping 0, 4, 8, C.
- Stall: at `pc_o`=8, assert `stall_i` for 2 cycles. Expect `pc_o` held at 8 for 2 cycles, then 0xC, with no flush.
- Branch over stall: assert `stall_i`, `branch_taken_i` and `branch_target_i`=0x100 together. Expect both flushes that cycle, `pc_o`=0x100 next, and `redirect_cnt_o` incremented by 1.
- Jump vs. branch: in one cycle assert `jump_i` (target 0x200) and branch (target 0x300). Expect `pc_o`=0x300 and both flushes. Then assert jump alone with target 0x203: expect `pc_o`=0x200 and `flush_ifid_o` only (macro off), or `pc_o`=0x80 (macro on).
- Wrap: with the PC at 0xFFFF_FFFC and no requests, expect `pc_o`=0x0 and `pc_plus4_o`=0x4.
- Reset mid-run and saturation:
  - Drop `rst_n` during a branch: expect `pc_o`=`RESET_PC`, no flush, and the counter at 0.
  - Force 65 540 redirects: expect `redirect_cnt_o` stuck at 0xFFFF.
